mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Byte-serial memory controller that shares the CPU's single 8-bit RAM port between instruction fetch (IF) and the load/store stage (MEM). It owns the port, splits 1/2/4-byte accesses into byte transfers, assembles little-endian read data, and returns per-port done pulses. It also raises per-port stall requests that the pipeline control unit turns into the `stall[5:0]` vector consumed by the stage registers.

## Interface
Parameters: none.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `if_req` in 1: fetch request, held until `if_done`.
- `if_addr` in 32: fetch byte address.
- `if_flush` in 1: abort any in-flight or pending fetch (branch redirect).
- `if_done` out 1: one-cycle pulse; `if_inst` is valid.
- `if_inst` out 32: fetched word.
- `mem_req` in 1: load/store request, held until `mem_done`.
- `mem_we` in 1: 1 = store, 0 = load.
- `mem_size` in 2: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: store data, LSB first.
- `mem_done` out 1: one-cycle pulse; load data is valid or the store is complete.
- `mem_rdata` out 32: raw load data, zero-extended. Sign extension is done by the MEM stage.
- `if_stall_req` out 1: equals `if_req & ~if_done`.
- `mem_stall_req` out 1: equals `mem_req & ~mem_done`.
- `ram_din` in 8: RAM read data. It is valid the cycle after its address is presented.
- `ram_dout` out 8: RAM write data.
- `ram_a` out 32: RAM address.
- `ram_wr` out 1: RAM write strobe.

## Operation
**States:** IDLE, IF_RD, MEM_RD, MEM_WR.

**Registers:**
- 3-bit byte counter `cnt`.
- Latched `base` address.
- Latched `N` (1, 2 or 4 bytes; IF is always 4).
- Latched write data.
- 32-bit assembly buffer.
- `done_if` and `done_mem` flags.

**Acceptance in IDLE:**
- Only when both done flags are 0.
- `mem_req` has priority over `if_req`.
- `if_req` is ignored while `if_flush` is high.
- On accept: latch address, size and data; clear the buffer; set `cnt = 0`; go to MEM_WR, MEM_RD or IF_RD.

**Read states:**
- Drive `ram_a = base + cnt` while `cnt < N`.
- Capture `ram_din` into buffer bits `[8k+7:8k]` in the cycle after byte k's address.
- After byte N-1 is captured: return to IDLE and set the port's done flag for exactly one cycle.
- Data output is the buffer with unread upper bytes at 0.

**MEM_WR:**
- Drive `ram_wr = 1`, `ram_a = base + cnt`, `ram_dout = wdata[8cnt+7:8cnt]`.
- After the last byte: go to IDLE and set `done_mem`.

**Address arithmetic:** `base + cnt` wraps modulo 2^32. No alignment requirement.

**Flush:**
- `if_flush` in IF_RD: go to IDLE at the end of that cycle. No further addresses are issued and no `if_done` is produced.
- `if_done = done_if & ~if_flush`.
- `if_flush` never affects MEM transactions. Loads and stores always run to completion.

**Ownership:** no preemption. A request arriving on the other port waits until the current transaction returns to IDLE.

**Idle/read outputs:** outside MEM_WR, `ram_wr = 0` and `ram_dout = 0`. `ram_a` holds its last value in IDLE.

**Reset:** takes effect at any point, including mid-store. All outputs go to 0 (`if_done`, `mem_done`, `if_inst`, `mem_rdata`, `ram_a`, `ram_dout`, `ram_wr`), state goes to IDLE, and `cnt = 0`. Any partial store is abandoned.

## Timing
- Cycle numbering: C0 is the cycle in which a request is accepted in IDLE.
- **Read of N bytes:**
  - Byte k address is driven in C(k+1) and its data is captured at the end of C(k+2).
  - Done is high in C(N+2).
  - Word fetch or load: done in C6. Byte load: done in C3.
- **Write of N bytes:**
  - Byte k is written in C(k+1).
  - Done is high in C(N+1). Word store: done in C5.
- A new request is accepted no earlier than the cycle after the done pulse (word load: next accept in C7).
- Stall requests are combinational from request and done, so the pipeline advances on the edge that ends the done cycle.

## Test plan
- **Word fetch:** `if_req` at `if_addr = 0x100`, RAM returns 0x13,0x05,0x10,0x00 → `ram_a` = 0x100..0x103 in C1–C4; `if_done` high in C6 only, with `if_inst = 0x00100513`; `if_stall_req` is 1 in C0–C5 and 0 in C6.
- **Simultaneous requests:** `if_req` and load-word `mem_req` both high in C0 → MEM is served first (`mem_done` in C6); fetch is accepted in C7 and `if_done` is high in C13.
- **Half store across wrap:** `mem_addr = 0xFFFFFFFF`, `wdata = 0xABCD` → C1: `ram_a = 0xFFFFFFFF`, `dout = 0xCD`, `wr = 1`; C2: `ram_a = 0x0`, `dout = 0xAB`, `wr = 1`; `mem_done` in C3.
- **Byte load zero-extension:** `mem_size = 0`, RAM byte 0xF0 → `mem_rdata = 0x000000F0`, `mem_done` in C3.
- **Flush mid-fetch:** `if_flush` pulsed in C3 of a fetch → no `ram_a` for byte 3 and no `if_done`; a new `if_req` is accepted in C4.
- **Reset mid-store:** `rst` asserted in C2 of a word store → next cycle `ram_wr = 0`, all outputs 0, state IDLE; a new request is accepted the cycle after `rst` deasserts.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - CPU-side request ports and byte-wide RAM port of the memory controller
interface mem_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_inst;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        if_stall_req;
  logic        mem_stall_req;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  modport master (
    output if_req, if_addr, if_flush, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
    input  if_done, if_inst, mem_done, mem_rdata, if_stall_req, mem_stall_req, ram_dout, ram_a, ram_wr
  );

  modport slave (
    input  if_req, if_addr, if_flush, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
    output if_done, if_inst, mem_done, mem_rdata, if_stall_req, mem_stall_req, ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM port arbiter for instruction fetch and load/store
module mem_ctrl (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  state_t      state;
  state_t      state_nx;
  logic [2:0]  cnt;
  logic [2:0]  n_bytes;
  logic [2:0]  size_n;
  logic [31:0] base;
  logic [31:0] wdata;
  logic [31:0] buffer;
  logic [31:0] a_hold;
  logic [31:0] addr_cur;
  logic [1:0]  cap_idx;
  logic        done_if;
  logic        done_mem;
  logic        accept_if;
  logic        accept_mem;
  logic        finish;
  logic        flushed;

  // Size code 3 is treated as a word.
  assign size_n   = (bus.mem_size == 2'd0) ? 3'd1 :
                    (bus.mem_size == 2'd1) ? 3'd2 : 3'd4;
  assign addr_cur = base + {29'd0, cnt};
  // The byte arriving now belongs to the address issued one cycle earlier.
  assign cap_idx  = cnt[1:0] - 2'd1;
  assign flushed  = (state == IF_RD) && bus.if_flush;

  assign bus.if_done       = done_if & ~bus.if_flush;
  assign bus.mem_done      = done_mem;
  assign bus.if_inst       = buffer;
  assign bus.mem_rdata     = buffer;
  assign bus.if_stall_req  = bus.if_req & ~bus.if_done;
  assign bus.mem_stall_req = bus.mem_req & ~bus.mem_done;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Arbitration, next state and RAM port drive.
  always_comb begin
    state_nx     = state;
    accept_if    = 1'b0;
    accept_mem   = 1'b0;
    finish       = 1'b0;
    bus.ram_a    = a_hold;
    bus.ram_wr   = 1'b0;
    bus.ram_dout = 8'd0;
    unique case (state)
      IDLE: begin
        // Wait out the done cycle so the requester can drop its request.
        if (!done_if && !done_mem) begin
          if (bus.mem_req) begin
            accept_mem = 1'b1;
            state_nx   = bus.mem_we ? MEM_WR : MEM_RD;
          end else if (bus.if_req && !bus.if_flush) begin
            accept_if = 1'b1;
            state_nx  = IF_RD;
          end
        end
      end
      IF_RD, MEM_RD: begin
        if (cnt < n_bytes) bus.ram_a = addr_cur;
        if (flushed) begin
          state_nx = IDLE;
        end else if (cnt == n_bytes) begin
          state_nx = IDLE;
          finish   = 1'b1;
        end
      end
      MEM_WR: begin
        bus.ram_wr   = 1'b1;
        bus.ram_a    = addr_cur;
        bus.ram_dout = wdata[{cnt[1:0], 3'b000} +: 8];
        if (cnt == n_bytes - 3'd1) begin
          state_nx = IDLE;
          finish   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Transaction latch, byte counter, read assembly and done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 3'd0;
      n_bytes  <= 3'd0;
      base     <= 32'd0;
      wdata    <= 32'd0;
      buffer   <= 32'd0;
      a_hold   <= 32'd0;
      done_if  <= 1'b0;
      done_mem <= 1'b0;
    end else begin
      a_hold   <= bus.ram_a;
      done_if  <= finish && (state == IF_RD);
      done_mem <= finish && (state != IF_RD);
      if (accept_mem) begin
        base    <= bus.mem_addr;
        n_bytes <= size_n;
        wdata   <= bus.mem_wdata;
        buffer  <= 32'd0;
        cnt     <= 3'd0;
      end else if (accept_if) begin
        base    <= bus.if_addr;
        n_bytes <= 3'd4;
        buffer  <= 32'd0;
        cnt     <= 3'd0;
      end else if (state == IF_RD || state == MEM_RD) begin
        if (flushed) begin
          cnt <= 3'd0;
        end else begin
          if (cnt != 3'd0) buffer[{cap_idx, 3'b000} +: 8] <= bus.ram_din;
          cnt <= finish ? 3'd0 : cnt + 3'd1;
        end
      end else if (state == MEM_WR) begin
        cnt <= finish ? 3'd0 : cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl
module tb_mem_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] ram [logic [31:0]];

  mem_ctrl_if bus();

  mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous byte RAM: read data valid the cycle after the address.
  always @(posedge clk) begin
    bus.ram_din <= ram.exists(bus.ram_a) ? ram[bus.ram_a] : 8'h00;
    if (bus.ram_wr) ram[bus.ram_a] = bus.ram_dout;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) ram[a + i] = w[8*i +: 8];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    #1;
    checks++;
    if (bus.ram_a !== 32'd0 || bus.ram_wr !== 1'b0 || bus.ram_dout !== 8'd0) begin
      errors++;
      $display("FAIL reset_ram: a=%h wr=%b dout=%h, want 0", bus.ram_a, bus.ram_wr, bus.ram_dout);
    end
    checks++;
    if (bus.if_done !== 1'b0 || bus.mem_done !== 1'b0 || bus.if_inst !== 32'd0 || bus.mem_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_out: ifd=%b memd=%b inst=%h rdata=%h, want 0", bus.if_done, bus.mem_done, bus.if_inst, bus.mem_rdata);
    end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    cyc();
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    #1;
    checks++;
    if (bus.if_stall_req !== 1'b1 || bus.if_done !== 1'b0) begin
      errors++;
      $display("FAIL fetch_c0: stall=%b done=%b, want 1 0", bus.if_stall_req, bus.if_done);
    end
    for (int c = 1; c <= 6; c++) begin
      cyc(); #1;
      if (c <= 4) begin
        checks++;
        if (bus.ram_a !== 32'h100 + c - 1) begin
          errors++;
          $display("FAIL fetch_addr C%0d: got %h want %h", c, bus.ram_a, 32'h100 + c - 1);
        end
      end
      checks++;
      if (bus.if_done !== (c == 6) || bus.if_stall_req !== (c != 6)) begin
        errors++;
        $display("FAIL fetch_done C%0d: done=%b stall=%b", c, bus.if_done, bus.if_stall_req);
      end
      if (c == 6) begin
        checks++;
        if (bus.if_inst !== 32'h00100513) begin
          errors++;
          $display("FAIL fetch_inst: got %h want 00100513", bus.if_inst);
        end
      end
    end
    cyc();
    bus.if_req = 1'b0;
    #1;
    checks++;
    if (bus.if_done !== 1'b0) begin
      errors++;
      $display("FAIL fetch_c7: if_done=%b want 0", bus.if_done);
    end
  endtask

  task automatic test_simultaneous();
    cyc();
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_size = 2'd2; bus.mem_addr = 32'h200;
    for (int c = 1; c <= 13; c++) begin
      cyc();
      if (c == 7) bus.mem_req = 1'b0;
      #1;
      checks++;
      if (bus.mem_done !== (c == 6) || bus.if_done !== (c == 13)) begin
        errors++;
        $display("FAIL simul_done C%0d: mem_done=%b if_done=%b", c, bus.mem_done, bus.if_done);
      end
      if (c == 1 || c == 8) begin
        checks++;
        if (bus.ram_a !== ((c == 1) ? 32'h200 : 32'h100)) begin
          errors++;
          $display("FAIL simul_addr C%0d: got %h", c, bus.ram_a);
        end
      end
      if (c == 6) begin
        checks++;
        if (bus.mem_rdata !== 32'h11223344) begin
          errors++;
          $display("FAIL simul_rdata: got %h want 11223344", bus.mem_rdata);
        end
      end
      if (c == 13) begin
        checks++;
        if (bus.if_inst !== 32'h00100513) begin
          errors++;
          $display("FAIL simul_inst: got %h want 00100513", bus.if_inst);
        end
      end
    end
    cyc();
    bus.if_req = 1'b0;
  endtask

  task automatic test_half_store_wrap();
    cyc();
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_size = 2'd1;
    bus.mem_addr = 32'hFFFF_FFFF; bus.mem_wdata = 32'h0000_ABCD;
    cyc(); #1;
    checks++;
    if (bus.ram_a !== 32'hFFFF_FFFF || bus.ram_dout !== 8'hCD || bus.ram_wr !== 1'b1) begin
      errors++;
      $display("FAIL wrap_c1: a=%h dout=%h wr=%b want ffffffff cd 1", bus.ram_a, bus.ram_dout, bus.ram_wr);
    end
    cyc(); #1;
    checks++;
    if (bus.ram_a !== 32'h0 || bus.ram_dout !== 8'hAB || bus.ram_wr !== 1'b1) begin
      errors++;
      $display("FAIL wrap_c2: a=%h dout=%h wr=%b want 00000000 ab 1", bus.ram_a, bus.ram_dout, bus.ram_wr);
    end
    cyc(); #1;
    checks++;
    if (bus.mem_done !== 1'b1 || bus.ram_wr !== 1'b0 || bus.mem_stall_req !== 1'b0) begin
      errors++;
      $display("FAIL wrap_c3: done=%b wr=%b stall=%b want 1 0 0", bus.mem_done, bus.ram_wr, bus.mem_stall_req);
    end
    cyc();
    bus.mem_req = 1'b0; bus.mem_we = 1'b0;
  endtask

  task automatic test_byte_load();
    cyc();
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_size = 2'd0; bus.mem_addr = 32'h300;
    for (int c = 1; c <= 3; c++) begin
      cyc(); #1;
      checks++;
      if (bus.mem_done !== (c == 3)) begin
        errors++;
        $display("FAIL byte_done C%0d: got %b", c, bus.mem_done);
      end
    end
    checks++;
    if (bus.mem_rdata !== 32'h0000_00F0) begin
      errors++;
      $display("FAIL byte_rdata: got %h want 000000f0", bus.mem_rdata);
    end
    cyc();
    bus.mem_req = 1'b0;
  endtask

  task automatic test_flush();
    cyc();
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      bus.if_flush = (c == 3);
      if (c == 3) bus.if_addr = 32'h400;
      #1;
      if (c == 4) begin
        checks++;
        if (bus.ram_a !== 32'h102) begin
          errors++;
          $display("FAIL flush_noaddr: got %h want 00000102", bus.ram_a);
        end
      end
      if (c == 5) begin
        checks++;
        if (bus.ram_a !== 32'h400) begin
          errors++;
          $display("FAIL flush_reaccept: got %h want 00000400", bus.ram_a);
        end
      end
      checks++;
      if (bus.if_done !== (c == 10)) begin
        errors++;
        $display("FAIL flush_done C%0d: got %b", c, bus.if_done);
      end
    end
    checks++;
    if (bus.if_inst !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL flush_inst: got %h want deadbeef", bus.if_inst);
    end
    cyc();
    bus.if_req = 1'b0;
    cyc();
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      bus.if_flush = (c == 6);
      if (c == 7) bus.if_req = 1'b0;
      #1;
      if (c >= 6) begin
        checks++;
        if (bus.if_done !== 1'b0) begin
          errors++;
          $display("FAIL flush_gate C%0d: if_done=%b want 0", c, bus.if_done);
        end
      end
    end
  endtask

  task automatic test_reset_mid_store();
    cyc();
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_size = 2'd2;
    bus.mem_addr = 32'h500; bus.mem_wdata = 32'h4433_2211;
    cyc(); #1;
    checks++;
    if (bus.ram_wr !== 1'b1 || bus.ram_dout !== 8'h11) begin
      errors++;
      $display("FAIL rststore_c1: wr=%b dout=%h want 1 11", bus.ram_wr, bus.ram_dout);
    end
    cyc();
    rst = 1'b1;
    #1;
    cyc();
    rst = 1'b0;
    bus.mem_we = 1'b0; bus.mem_addr = 32'h200;
    #1;
    checks++;
    if (bus.ram_wr !== 1'b0 || bus.ram_a !== 32'd0 || bus.ram_dout !== 8'd0) begin
      errors++;
      $display("FAIL rststore_ram: wr=%b a=%h dout=%h want 0", bus.ram_wr, bus.ram_a, bus.ram_dout);
    end
    checks++;
    if (bus.mem_done !== 1'b0 || bus.if_inst !== 32'd0 || bus.mem_rdata !== 32'd0 || bus.if_done !== 1'b0) begin
      errors++;
      $display("FAIL rststore_out: memd=%b inst=%h rdata=%h ifd=%b want 0", bus.mem_done, bus.if_inst, bus.mem_rdata, bus.if_done);
    end
    for (int c = 1; c <= 6; c++) begin
      cyc(); #1;
      if (c == 1) begin
        checks++;
        if (bus.ram_a !== 32'h200) begin
          errors++;
          $display("FAIL rststore_accept: got %h want 00000200", bus.ram_a);
        end
      end
      checks++;
      if (bus.mem_done !== (c == 6)) begin
        errors++;
        $display("FAIL rststore_done C%0d: got %b", c, bus.mem_done);
      end
    end
    checks++;
    if (bus.mem_rdata !== 32'h1122_3344 || ram.exists(32'h502)) begin
      errors++;
      $display("FAIL rststore_data: rdata=%h byte2_written=%b", bus.mem_rdata, ram.exists(32'h502));
    end
    cyc();
    bus.mem_req = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = 32'd0; bus.if_flush = 1'b0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_size = 2'd0;
    bus.mem_addr = 32'd0; bus.mem_wdata = 32'd0;
    put_word(32'h100, 32'h0010_0513);
    put_word(32'h200, 32'h1122_3344);
    put_word(32'h300, 32'h5566_77F0);
    put_word(32'h400, 32'hDEAD_BEEF);
    test_reset();
    test_fetch();
    test_simultaneous();
    test_half_store_wrap();
    test_byte_load();
    test_flush();
    test_reset_mid_store();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
